conv_out_packer: RTL
====================

Name: conv_out_packer

Overview:
- Downstream stage of conv_top. Consumes its unflow-controlled 64-bit data_out stream, which carries 8 int8 output channels per word.
- Pairs consecutive words into 128-bit AXI-Stream beats and buffers them in a FIFO so that DMA backpressure can be absorbed.
- Counts words per layer pass, marks the final beat with tlast and reports done.
- Any word that arrives while the FIFO is full is lost; this is reported through a sticky overflow flag, because conv_top cannot stall.

Parameters:
- IN_W, 64, input word width (8 channels x int8).
- OUT_W, 128, output beat width; fixed at 2*IN_W.
- FIFO_DEPTH, 64, number of output beats buffered; must be a power of 2.
- CNT_W, 24, width of the word counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_out_words  in  CNT_W  number of IN_W words expected this pass; sampled on start.
- start  in  1  one-cycle pulse that arms the block.
- data_in  in  IN_W  conv_top data_out.
- data_in_valid  in  1  conv_top data_out_valid.
- m_axis_tdata  out  OUT_W  packed beat; the first word of a pair is in the low half.
- m_axis_tkeep  out  OUT_W/8  16'hFFFF for a full beat, 16'h00FF for a half beat.
- m_axis_tlast  out  1  final beat of the pass.
- m_axis_tvalid  out  1  beat available.
- m_axis_tready  in  1  downstream accept.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE; FIFO is empty; half register is empty; counters are 0.
  - The asynchronous reset aborts any operation in progress immediately. Buffered data is discarded.
- FSM has four states: IDLE, RUN, FLUSH, FIN.
- IDLE:
  - data_in_valid is ignored.
  - On start: latch cfg_out_words, clear word_cnt, clear overflow, clear the half register, and set busy.
  - If the latched count is 0, go to FIN. Otherwise go to RUN.
- RUN, on each data_in_valid:
  - If the half register is empty, store data_in in it.
  - Otherwise push {data_in, half} with keep-half=0 and empty the half register.
  - word_cnt increments on every valid, including words that are dropped.
  - last is set on the push that coincides with word_cnt reaching cfg_out_words-1.
  - When the final word is accepted and the total count is odd, go to FLUSH. When it is even, go to FIN after that push.
- FLUSH: push {64'h0, half} with keep-half=1 and last=1 in one cycle, then go to FIN.
- FIN:
  - Wait until the FIFO is empty and no beat is pending.
  - When the last beat handshakes (tvalid & tready & tlast), pulse done and clear busy on that same edge, then return to IDLE.
  - For a count of 0, pulse done one cycle after start, with no beats emitted.
- FIFO:
  - Each entry is OUT_W data bits plus 1 last bit plus 1 keep-half bit.
  - First-word-fall-through: a push at edge N makes tvalid visible after edge N.
  - Push and pop in the same cycle are both performed, even when the FIFO is full.
  - If the FIFO is full, the word or pair being pushed is dropped and overflow is set. A full FIFO with a simultaneous pop is not full.
  - If a last push is dropped, done never fires. Recovery from this case is by reset.
- AXI-Stream rules: tdata, tkeep and tlast are held stable while tvalid & !tready. tvalid never drops without a handshake.
- Ignored events:
  - start while busy is ignored.
  - data_in_valid in FLUSH or FIN, or after the count is reached, is ignored and not counted.
- fifo_level is exact and registered.
- Sustained throughput is 1 input word per cycle, giving 1 output beat every 2 cycles.

Decomposition:
- Package conv_out_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, FIN);
  - the KEEP_FULL and KEEP_HALF constants;
  - the fifo_entry_t packed struct {last, keep_half, data}.
- Sub-module sync_fifo_fwft provides the FIFO, parameterised on WIDTH and DEPTH. It has push, pop, full, empty and level, and uses the same asynchronous active-low reset.

Test Plan:
- cfg_out_words=8, 8 consecutive words 0x0..0x7 with tready=1 -> 4 beats: {1,0}, {3,2}, {5,4}, {7,6}; tkeep=FFFF; tlast on beat 4; done 1 cycle after that handshake.
- cfg_out_words=5 with gapped valids -> 3 beats; beat 3 = {0, w4}, tkeep=00FF, tlast=1; overflow=0.
- tready=0 throughout, with 2*FIFO_DEPTH+4 words -> fifo_level=64, overflow=1. Then raise tready -> exactly 64 beats drain and data is unchanged under stall. Only reset recovers (done never fires).
- cfg_out_words=0, start -> busy for 1 cycle, done pulse, no tvalid.
- start pulsed mid-RUN and extra valids after the count is reached -> both ignored; beat count and last position unchanged.
- rst_n asserted mid-pass, with 3 beats buffered and tvalid high -> next cycle tvalid=0, fifo_level=0, busy=0. A fresh start then completes normally.

Source files
------------

// File: rtl/conv_out_pkg.sv
// ============================================================================
// conv_out_pkg : shared types and constants for the conv_top output packer
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_out_pkg;

    localparam int          PKT_DATA_W = 128;
    localparam logic [15:0] KEEP_FULL  = 16'hFFFF;
    localparam logic [15:0] KEEP_HALF  = 16'h00FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  last;
        logic                  keep_half;
        logic [PKT_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// sync_fifo_fwft : single-clock first-word-fall-through FIFO, exact level
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok, pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_out_packer.sv
// ============================================================================
// conv_out_packer : pairs conv_top words into AXI-Stream beats with tlast/done
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_out_packer
    import conv_out_pkg::*;
#(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 128,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CNT_W-1:0]            cfg_out_words,
    input  logic                        start,
    input  logic [IN_W-1:0]             data_in,
    input  logic                        data_in_valid,
    output logic [OUT_W-1:0]            m_axis_tdata,
    output logic [OUT_W/8-1:0]          m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [IN_W-1:0]  half_q, half_d;
    logic             half_vld_q, half_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    fifo_entry_t      push_entry, pop_entry;
    logic             push, pop, fifo_full, fifo_empty;
    logic             final_word, last_hs;

    assign pop        = m_axis_tready & ~fifo_empty;
    assign final_word = (word_cnt_q == target_q - CNT_ONE);
    assign last_hs    = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        word_cnt_d = word_cnt_q;
        half_d     = half_q;
        half_vld_d = half_vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        push       = 1'b0;
        push_entry = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d   = cfg_out_words;
                    word_cnt_d = '0;
                    ovf_d      = 1'b0;
                    half_vld_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (cfg_out_words == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (data_in_valid) begin
                    word_cnt_d = word_cnt_q + CNT_ONE;
                    if (!half_vld_q) begin
                        half_d     = data_in;
                        half_vld_d = 1'b1;
                        if (final_word) state_d = FLUSH;
                    end else begin
                        push                 = 1'b1;
                        push_entry.data      = {data_in, half_q};
                        push_entry.keep_half = 1'b0;
                        push_entry.last      = final_word;
                        half_vld_d           = 1'b0;
                        if (final_word) state_d = FIN;
                    end
                end
            end
            FLUSH: begin
                push                 = 1'b1;
                push_entry.data      = {{IN_W{1'b0}}, half_q};
                push_entry.keep_half = 1'b1;
                push_entry.last      = 1'b1;
                half_vld_d           = 1'b0;
                state_d              = FIN;
            end
            FIN: begin
                // An empty pass has no beat to wait for; otherwise the tlast handshake ends it.
                if (target_q == '0 || last_hs) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            word_cnt_q <= '0;
            half_q     <= '0;
            half_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            word_cnt_q <= word_cnt_d;
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (pop_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Payload is forced to zero while no beat is presented so idle outputs read as 0.
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : pop_entry.data;
    assign m_axis_tkeep  = fifo_empty ? '0 : (pop_entry.keep_half ? KEEP_HALF : KEEP_FULL);
    assign m_axis_tlast  = ~fifo_empty & pop_entry.last;

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire
